resize_accel_mul_pipe: RTL and testbench
========================================

# resize_accel_mul_pipe

Parametrised, pipelined fixed-point multiplier for the resize accelerator datapath. It is the successor to the fixed 16x16->32 unsigned DSP multiplier and adds configurable operand and result widths, per-operand signedness, fractional right-shift with round-half-up, optional saturation with an overflow flag, a sideband tag, and valid/ready flow control with per-stage stalling. It sits between the coordinate/weight generators and the interpolation accumulators.

## Interface
- A_WIDTH, 16: width of operand a.
- B_WIDTH, 16: width of operand b.
- P_WIDTH, 32: width of the result.
- STAGES, 4: pipeline depth. Must be at least 3.
- SIGNED_A, 0: 1 treats a as two's complement; 0 treats it as unsigned.
- SIGNED_B, 0: the same as SIGNED_A, for b.
- FRAC_SHIFT, 0: arithmetic right shift applied to the full product.
- ROUND, 0: 1 adds 2^(FRAC_SHIFT-1) before the shift. It is ignored when FRAC_SHIFT=0.
- SATURATE, 0: 1 clamps the result to the P_WIDTH range; 0 truncates it.
- TAG_WIDTH, 8: width of the sideband tag that passes through with each beat.
- clk, in, 1: clock. All logic is on the rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- flush, in, 1: synchronous clear that drops all in-flight beats.
- in_valid, in, 1: the input beat is valid.
- in_ready, out, 1: the block can accept a beat.
- in_a, in, A_WIDTH: operand a.
- in_b, in, B_WIDTH: operand b.
- in_tag, in, TAG_WIDTH: sideband tag.
- out_valid, out, 1: the result beat is valid.
- out_ready, in, 1: the downstream block accepts the result.
- out_p, out, P_WIDTH: the result.
- out_ovf, out, 1: set when saturation or truncation changed the value.
- out_tag, out, TAG_WIDTH: the tag of the beat on out_p.

## Operation
- A beat is accepted when in_valid && in_ready. A beat is delivered when out_valid && out_ready.
- Stage 1 registers a, b and the tag.
- Stage 2 forms the full product, FW = A_WIDTH+B_WIDTH+1 bits:
  - a is sign- or zero-extended according to SIGNED_A; b according to SIGNED_B.
  - The product is signed if SIGNED_A or SIGNED_B is 1.
- Stages 3..STAGES-1 are plain delay registers.
- The final stage applies, in order: the rounding add, the arithmetic shift by FRAC_SHIFT, then saturation or truncation into P_WIDTH. It registers out_p and out_ovf.
- Result range:
  - Signed products clamp to [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1].
  - Unsigned products clamp to [0, 2^P_WIDTH-1].
  - out_ovf=1 whenever the clamped or truncated value differs from the shifted value.
- Each stage carries a valid bit. A stage loads when it is empty or when its successor loads; otherwise it holds. Bubbles therefore collapse.
- in_ready = !v[1] || (stage 1 advances), gated low while reset_n is low.
- flush=1 clears all valid bits at the clock edge and out_valid is 0 on the next cycle. A beat offered in the same cycle as flush is dropped; in_ready remains as computed.
- Ordering: results leave in acceptance order, with no loss or duplication.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, when there is no stall.
- Throughput: one beat per cycle while out_ready=1.
- Capacity: when out_ready is held low, the pipe absorbs exactly STAGES beats, then in_ready goes to 0. The beat on out_p, out_ovf and out_tag is held stable until it is accepted.
- out_ready rising allows a new acceptance in the same cycle, because in_ready depends combinationally on out_ready.
- Reset, asynchronous and active-low:
  - All valid bits, out_valid, out_p, out_ovf and out_tag go to 0 immediately.
  - Data registers are also cleared.
  - in_ready=0 while reset_n=0 and becomes 1 in the first cycle after release.
  - An assertion mid-stream discards all in-flight beats.
- Elaboration errors: STAGES<3, FRAC_SHIFT>=FW, P_WIDTH<1.

## Structure
- Package resize_accel_mul_pkg holds:
  - the result-signedness and FW derivation functions;
  - the rounding-constant function;
  - the saturation-bound functions.
- Sub-module resize_accel_mul_round_sat is the combinational round, shift and saturate/truncate logic with the ovf output, used by the final stage.
- The top level holds the valid-bit pipeline, the stall logic, the product register and the delay registers.

## Test plan
- Defaults, unsigned: a=0xFFFF, b=0xFFFF → out_p=0xFFFE0001, ovf=0. Appears STAGES-1 cycles after acceptance; tag 0x5A is carried through.
- SIGNED_A=SIGNED_B=1: a=0xFFFD (-3), b=0x0005 → out_p=0xFFFFFFF1 (-15). With SIGNED_B=0 and b=0x8000 (32768): a=-3 → -98304 = 0xFFFE8000.
- FRAC_SHIFT=8, ROUND=1:
  - a=0x0180, b=0x0001 → out_p=2.
  - With ROUND=0 → 1.
  - Signed, a=-0x0180 (0xFE80), b=1, ROUND=1 → -1.
- P_WIDTH=16, SATURATE=1, unsigned: a=0x0100, b=0x0100 → out_p=0xFFFF, ovf=1. With SATURATE=0 → 0x0000, ovf=1.
- Backpressure:
  - Stream 20 tagged beats, holding out_ready low for cycles 5–14.
  - in_ready drops after exactly STAGES beats are buffered.
  - All 20 results arrive in order, with outputs stable during the stall.
- Flush and reset:
  - flush with 3 beats in flight → no output from them, and the next beat has normal latency.
  - reset_n low mid-stream → outputs are 0 immediately, and in_ready=0 until release.

Source files
------------

// File: rtl/resize_accel_mul_pkg.sv
// Width, rounding and saturation helpers shared by the resize-accelerator multiplier.
// All helpers are constant functions evaluated at elaboration.
package resize_accel_mul_pkg;

  localparam int MAX_W = 128;
  typedef logic [MAX_W-1:0] wide_t;

  function automatic int full_width(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  function automatic bit result_signed(input int sa, input int sb);
    return (sa != 0) || (sb != 0);
  endfunction

  // Working width for round/shift/clamp: holds the rounded product and both result bounds.
  function automatic int calc_width(input int fw, input int p_w);
    return (fw > p_w) ? fw + 1 : p_w + 1;
  endfunction

  function automatic wide_t round_const(input int shift, input int round_en);
    wide_t c;
    c = '0;
    if (round_en != 0 && shift > 0) c = wide_t'(1) << (shift - 1);
    return c;
  endfunction

  function automatic wide_t sat_max(input int p_w, input bit is_signed);
    return (wide_t'(1) << (p_w - (is_signed ? 1 : 0))) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int p_w, input bit is_signed);
    wide_t m;
    m = '0;
    if (is_signed) m = ~((wide_t'(1) << (p_w - 1)) - wide_t'(1));
    return m;
  endfunction

endpackage

// File: rtl/resize_accel_mul_pipe_if.sv
// Input and result channels of the multiplier pipe; slave is the pipe, master the producer/consumer side.
interface resize_accel_mul_pipe_if #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int P_WIDTH   = 32,
  parameter int TAG_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   in_a;
  logic [B_WIDTH-1:0]   in_b;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [P_WIDTH-1:0]   out_p;
  logic                 out_ovf;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_ovf, out_tag
  );
endinterface

// File: rtl/resize_accel_mul_round_sat.sv
// Combinational round-half-up, arithmetic right shift and clamp/truncate into P_WIDTH.
// ovf_o flags any value that does not fit the result range, whether clamped or truncated.
module resize_accel_mul_round_sat
  import resize_accel_mul_pkg::*;
#(
  parameter int FW         = 33,
  parameter int P_WIDTH    = 32,
  parameter int FRAC_SHIFT = 0,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 0,
  parameter int RES_SIGNED = 0
) (
  input  logic signed [FW-1:0] prod_i,
  output logic [P_WIDTH-1:0]   p_o,
  output logic                 ovf_o
);
  localparam int    CW     = calc_width(FW, P_WIDTH);
  localparam wide_t RND_W  = round_const(FRAC_SHIFT, ROUND);
  localparam wide_t HI_W   = sat_max(P_WIDTH, RES_SIGNED != 0);
  localparam wide_t LO_W   = sat_min(P_WIDTH, RES_SIGNED != 0);
  localparam logic signed [CW-1:0] RND = RND_W[CW-1:0];
  localparam logic signed [CW-1:0] HI  = HI_W[CW-1:0];
  localparam logic signed [CW-1:0] LO  = LO_W[CW-1:0];

  logic signed [CW-1:0] rounded;
  logic signed [CW-1:0] shifted;
  logic                 above;
  logic                 below;

  // Unsigned products never set bit FW-1, so sign extension is correct for both modes.
  always_comb begin
    rounded = CW'(prod_i) + RND;
    shifted = rounded >>> FRAC_SHIFT;
    above   = shifted > HI;
    below   = shifted < LO;
    ovf_o   = above || below;
    p_o     = shifted[P_WIDTH-1:0];
    if (SATURATE != 0 && above)      p_o = HI[P_WIDTH-1:0];
    else if (SATURATE != 0 && below) p_o = LO[P_WIDTH-1:0];
  end

endmodule

// File: rtl/resize_accel_mul_pipe.sv
// Pipelined fixed-point multiplier with valid/ready flow control, per-stage stalling,
// tag sideband and flush. Stage 1 registers operands, stage 2 the product, last stage the result.
module resize_accel_mul_pipe
  import resize_accel_mul_pkg::*;
#(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 16,
  parameter int P_WIDTH    = 32,
  parameter int STAGES     = 4,
  parameter int SIGNED_A   = 0,
  parameter int SIGNED_B   = 0,
  parameter int FRAC_SHIFT = 0,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 0,
  parameter int TAG_WIDTH  = 8
) (
  input logic                    clk,
  input logic                    reset_n,
  input logic                    flush,
  resize_accel_mul_pipe_if.slave bus
);
  localparam int FW         = full_width(A_WIDTH, B_WIDTH);
  localparam bit RES_SIGNED = result_signed(SIGNED_A, SIGNED_B);

  if (STAGES < 3) begin : g_bad_stages
    $error("resize_accel_mul_pipe: STAGES must be at least 3");
  end
  if (FRAC_SHIFT >= FW) begin : g_bad_shift
    $error("resize_accel_mul_pipe: FRAC_SHIFT must be below the full product width");
  end
  if (P_WIDTH < 1) begin : g_bad_pwidth
    $error("resize_accel_mul_pipe: P_WIDTH must be at least 1");
  end
  if (calc_width(FW, P_WIDTH) > MAX_W) begin : g_bad_width
    $error("resize_accel_mul_pipe: operand/result widths exceed the helper width");
  end

  logic [STAGES:1]        v_q;
  logic [STAGES:1]        load;
  logic                   accept;
  logic [A_WIDTH-1:0]     a_q;
  logic [B_WIDTH-1:0]     b_q;
  logic signed [FW-1:0]   a_ext;
  logic signed [FW-1:0]   b_ext;
  logic signed [FW-1:0]   prod_q [2:STAGES-1];
  logic [TAG_WIDTH-1:0]   tag_q  [1:STAGES];
  logic [P_WIDTH-1:0]     p_q;
  logic [P_WIDTH-1:0]     p_d;
  logic                   ovf_q;
  logic                   ovf_d;

  // A stage loads when it is empty or its successor loads, so bubbles collapse.
  always_comb begin : p_load_chain
    logic downstream;
    // NOTE: every always_comb output gets a default before any conditional write, otherwise a latch is inferred.
    load           = '0;
    downstream     = !v_q[STAGES] || bus.out_ready;
    load[STAGES]   = downstream;
    for (int k = STAGES - 1; k >= 1; k--) begin
      downstream = !v_q[k] || downstream;
      load[k]    = downstream;
    end
  end

  assign bus.in_ready = load[1] && reset_n;
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
    end else if (flush) begin
      v_q <= '0;
    end else begin
      if (load[1]) v_q[1] <= accept;
      for (int k = 2; k <= STAGES; k++) begin
        if (load[k]) v_q[k] <= v_q[k-1];
      end
    end
  end

  always_comb begin
    a_ext = {{(FW - A_WIDTH){(SIGNED_A != 0) && a_q[A_WIDTH-1]}}, a_q};
    b_ext = {{(FW - B_WIDTH){(SIGNED_B != 0) && b_q[B_WIDTH-1]}}, b_q};
  end

  // NOTE: data registers are reset too, so out_p/out_tag read zero straight out of reset;
  // flush only touches the valid bits because stale data behind a cleared valid is harmless.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 1; k <= STAGES; k++)     tag_q[k]  <= '0;
      for (int k = 2; k <= STAGES - 1; k++) prod_q[k] <= '0;
    end else begin
      if (load[1]) begin
        a_q      <= bus.in_a;
        b_q      <= bus.in_b;
        tag_q[1] <= bus.in_tag;
      end
      if (load[2]) begin
        prod_q[2] <= a_ext * b_ext;
        tag_q[2]  <= tag_q[1];
      end
      for (int k = 3; k <= STAGES - 1; k++) begin
        if (load[k]) begin
          prod_q[k] <= prod_q[k-1];
          tag_q[k]  <= tag_q[k-1];
        end
      end
      if (load[STAGES]) begin
        p_q           <= p_d;
        ovf_q         <= ovf_d;
        tag_q[STAGES] <= tag_q[STAGES-1];
      end
    end
  end

  resize_accel_mul_round_sat #(
    .FW         (FW),
    .P_WIDTH    (P_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT),
    .ROUND      (ROUND),
    .SATURATE   (SATURATE),
    .RES_SIGNED (RES_SIGNED ? 1 : 0)
  ) u_round_sat (
    .prod_i (prod_q[STAGES-1]),
    .p_o    (p_d),
    .ovf_o  (ovf_d)
  );

  assign bus.out_valid = v_q[STAGES];
  assign bus.out_p     = p_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_tag   = tag_q[STAGES];

endmodule

// File: tb/tb_resize_accel_mul_pipe.sv
// Self-checking bench: eight parameter configurations driven in parallel, table-driven
// arithmetic vectors plus hand-written backpressure, flush and reset sequences on config 0.
module tb_resize_accel_mul_pipe;
  localparam int STAGES = 4;
  localparam int N_CFG  = 8;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic [31:0] res_p        [N_CFG];
  logic        res_ovf      [N_CFG];
  logic        res_valid    [N_CFG];
  logic        res_in_ready [N_CFG];
  logic [7:0]  res_tag      [N_CFG];

  int n_checks = 0;
  int n_errors = 0;

  // cfg: 0 default, 1 signed*signed, 2 signed*unsigned, 3 shift8+round, 4 shift8,
  //      5 signed shift8+round, 6 P16 saturate, 7 P16 truncate
  for (genvar g = 0; g < N_CFG; g++) begin : g_dut
    localparam int SA  = (g == 1 || g == 2 || g == 5) ? 1 : 0;
    localparam int SB  = (g == 1 || g == 5) ? 1 : 0;
    localparam int FS  = (g >= 3 && g <= 5) ? 8 : 0;
    localparam int RN  = (g == 3 || g == 5) ? 1 : 0;
    localparam int PW  = (g >= 6) ? 16 : 32;
    localparam int SAT = (g == 6) ? 1 : 0;

    resize_accel_mul_pipe_if #(.A_WIDTH(16), .B_WIDTH(16), .P_WIDTH(PW), .TAG_WIDTH(8)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.in_a      = in_a;
    assign bus.in_b      = in_b;
    assign bus.in_tag    = in_tag;
    assign bus.out_ready = out_ready;
    assign res_p[g]        = 32'(bus.out_p);
    assign res_ovf[g]      = bus.out_ovf;
    assign res_valid[g]    = bus.out_valid;
    assign res_in_ready[g] = bus.in_ready;
    assign res_tag[g]      = bus.out_tag;

    resize_accel_mul_pipe #(
      .A_WIDTH(16), .B_WIDTH(16), .P_WIDTH(PW), .STAGES(STAGES),
      .SIGNED_A(SA), .SIGNED_B(SB), .FRAC_SHIFT(FS), .ROUND(RN),
      .SATURATE(SAT), .TAG_WIDTH(8)
    ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .bus     (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  tag;
    logic [31:0] p;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          sent;
    int          rcvd;
    int          occ;
    bit          stalled_prev;
    bit          seen;
    logic [31:0] held_p;
    logic [7:0]  held_tag;
    logic [31:0] exp_q[$];
    logic [7:0]  exp_tag_q[$];

    vecs.push_back('{0, 16'hFFFF, 16'hFFFF, 8'h5A, 32'hFFFE0001, 1'b0});
    vecs.push_back('{1, 16'hFFFD, 16'h0005, 8'h11, 32'hFFFFFFF1, 1'b0});
    vecs.push_back('{2, 16'hFFFD, 16'h8000, 8'h12, 32'hFFFE8000, 1'b0});
    vecs.push_back('{3, 16'h0180, 16'h0001, 8'h13, 32'h00000002, 1'b0});
    vecs.push_back('{4, 16'h0180, 16'h0001, 8'h14, 32'h00000001, 1'b0});
    vecs.push_back('{5, 16'hFE80, 16'h0001, 8'h15, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{6, 16'h0100, 16'h0100, 8'h16, 32'h0000FFFF, 1'b1});
    vecs.push_back('{7, 16'h0100, 16'h0100, 8'h17, 32'h00000000, 1'b1});
    vecs.push_back('{1, 16'h8000, 16'h8000, 8'h18, 32'h40000000, 1'b0});
    vecs.push_back('{6, 16'h00FF, 16'h0101, 8'h19, 32'h0000FFFF, 1'b0});
    vecs.push_back('{0, 16'h0000, 16'h1234, 8'h1A, 32'h00000000, 1'b0});
    vecs.push_back('{5, 16'h0001, 16'h0080, 8'h1B, 32'h00000001, 1'b0});
    vecs.push_back('{5, 16'hFFFF, 16'h0080, 8'h1C, 32'h00000000, 1'b0});
    vecs.push_back('{7, 16'h0123, 16'h0100, 8'h1D, 32'h00002300, 1'b1});
    vecs.push_back('{3, 16'h00FF, 16'h0001, 8'h1E, 32'h00000001, 1'b0});

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    #2;
    for (int g = 0; g < N_CFG; g++) begin
      check($sformatf("rst_valid[%0d]", g), res_valid[g], 0);
      check($sformatf("rst_p[%0d]", g), res_p[g], 0);
      check($sformatf("rst_in_ready[%0d]", g), res_in_ready[g], 0);
    end
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", res_in_ready[0], 1);

    // Arithmetic vectors: one isolated beat each, exact latency checked.
    foreach (vecs[i]) begin
      in_valid = 1'b1;
      in_a     = vecs[i].a;
      in_b     = vecs[i].b;
      in_tag   = vecs[i].tag;
      tick();
      in_valid = 1'b0;
      repeat (STAGES - 2) tick();
      check($sformatf("vec%0d_early", i), res_valid[vecs[i].sel], 0);
      tick();
      check($sformatf("vec%0d_valid", i), res_valid[vecs[i].sel], 1);
      check($sformatf("vec%0d_p", i), res_p[vecs[i].sel], vecs[i].p);
      check($sformatf("vec%0d_ovf", i), res_ovf[vecs[i].sel], vecs[i].ovf);
      check($sformatf("vec%0d_tag", i), res_tag[vecs[i].sel], vecs[i].tag);
      tick();
    end

    // Backpressure: 20 beats, input bubbles in cycles 2-3, out_ready low in cycles 5-14.
    sent         = 0;
    rcvd         = 0;
    stalled_prev = 1'b0;
    held_p       = '0;
    held_tag     = '0;
    for (int c = 0; c < 200 && rcvd < 20; c++) begin
      out_ready = !(c >= 5 && c <= 14);
      in_valid  = (sent < 20) && !(c == 2 || c == 3);
      in_a      = 16'hF000 + 16'(sent * 37);
      in_b      = 16'h0100 + 16'(sent * 291);
      in_tag    = 8'h80 + 8'(sent);
      #1;
      occ = sent - rcvd;
      check($sformatf("bp_in_ready_c%0d", c), res_in_ready[0], (out_ready || occ < STAGES));
      if (stalled_prev) begin
        check($sformatf("bp_hold_valid_c%0d", c), res_valid[0], 1);
        check($sformatf("bp_hold_p_c%0d", c), res_p[0], held_p);
        check($sformatf("bp_hold_tag_c%0d", c), res_tag[0], held_tag);
      end
      if (res_valid[0] && out_ready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("bp_spurious_c%0d", c), 1, 0);
        end else begin
          check($sformatf("bp_p_%0d", rcvd), res_p[0], exp_q.pop_front());
          check($sformatf("bp_tag_%0d", rcvd), res_tag[0], exp_tag_q.pop_front());
        end
        rcvd++;
      end
      stalled_prev = res_valid[0] && !out_ready;
      held_p       = res_p[0];
      held_tag     = res_tag[0];
      if (in_valid && res_in_ready[0]) begin
        exp_q.push_back(32'(in_a) * 32'(in_b));
        exp_tag_q.push_back(in_tag);
        sent++;
      end
      @(posedge clk);
      #1;
    end
    check("bp_count", rcvd, 20);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Flush with three beats in flight; the beat offered alongside flush is dropped.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = 16'(i + 2);
      in_b     = 16'h0003;
      in_tag   = 8'hC0 + 8'(i);
      tick();
    end
    check("fl_pre_valid", res_valid[0], 0);
    flush    = 1'b1;
    in_a     = 16'h0077;
    in_tag   = 8'hEE;
    #1;
    check("fl_in_ready", res_in_ready[0], 1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid_next", res_valid[0], 0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (res_valid[0]) seen = 1'b1;
      tick();
    end
    check("fl_no_output", seen, 0);
    in_valid = 1'b1;
    in_a     = 16'h0010;
    in_b     = 16'h0011;
    in_tag   = 8'hD1;
    tick();
    in_valid = 1'b0;
    repeat (STAGES - 2) tick();
    check("fl_next_early", res_valid[0], 0);
    tick();
    check("fl_next_valid", res_valid[0], 1);
    check("fl_next_p", res_p[0], 32'h00000110);
    check("fl_next_tag", res_tag[0], 8'hD1);
    tick();

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = 16'(i + 1);
      in_b     = 16'h0005;
      in_tag   = 8'hA0 + 8'(i);
      tick();
    end
    check("rst_pre_valid", res_valid[0], 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid", res_valid[0], 0);
    check("rst_mid_p", res_p[0], 0);
    check("rst_mid_tag", res_tag[0], 0);
    check("rst_mid_in_ready", res_in_ready[0], 0);
    tick();
    tick();
    check("rst_hold_in_ready", res_in_ready[0], 0);
    check("rst_hold_valid", res_valid[0], 0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    check("rst_rel_in_ready", res_in_ready[0], 1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (res_valid[0]) seen = 1'b1;
    end
    check("rst_no_stale_output", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
